// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state encoding and widths for the RV32I control sequencer
package rv_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INCR = XLEN'(4);
    typedef enum logic {FETCH, EXEC} state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: jump/branch target priority mux; MISALIGN_TRAP_EN keeps raw targets and flags misalignment
module next_pc_calc
    import rv_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            is_branch,
    input  logic            branch_taken,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);
    logic [XLEN-1:0] target;
    assign target = is_jalr ? ((rs1_val + imm) & ~XLEN'(1)) :
                    (is_jal || (is_branch && branch_taken)) ? (pc + imm) : (pc + PC_INCR);
`ifdef MISALIGN_TRAP_EN
    assign pc_next    = target;
    assign misaligned = |target[1:0];
`else
    assign pc_next    = target & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: RV32I PC owner and fetch/execute handshake FSM; MISALIGN_TRAP_EN enables target traps
module pc_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            is_branch,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] link_value,
    output logic            link_we,
    output logic            trap
);
    state_t state;
    logic   misaligned;
    logic   fire;

    next_pc_calc u_calc (
        .pc           (pc_current),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .pc_next      (pc_next),
        .misaligned   (misaligned)
    );

    assign imem_addr  = pc_current;
    assign link_value = pc_current + PC_INCR;
    assign fire       = (state == EXEC) && exec_done;
    assign link_we    = fire && (is_jal || is_jalr) && !misaligned;
    assign trap       = fire && misaligned;

    // imem_req is held low through reset and the first cycle after it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_current  <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else if (state == FETCH) begin
            if (imem_req && imem_ready) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
                imem_req    <= 1'b0;
                state       <= EXEC;
            end else begin
                imem_req <= 1'b1;
            end
        end else if (exec_done) begin
            pc_current  <= misaligned ? TRAP_VEC : pc_next;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
        end
    end
endmodule
